control_seq: RTL

CONTROL_SEQ -- requirements
Module: control_seq

---
 rtl/control_seq_if.sv | 47 ++++
 rtl/control_seq.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/control_seq_if.sv
// Bundle between the multicycle control sequencer and its datapath:
// decode inputs flowing in, datapath control flags and debug state flowing out.
interface control_seq_if;
   logic [5:0] OPCode;
   logic [5:0] Funct;
   logic       Overflow;
   logic       DivZero;
   logic       MDDone;

   logic [4:0] Estado;
   logic       flagPcWrite;
   logic       flagIrWrite;
   logic       flagRegWrite;
   logic       flagRegA;
   logic       flagRegB;
   logic       flagALUOut;
   logic       flagEPC;
   logic       flagMultStart;
   logic       flagDivStart;
   logic       flagRegHighW;
   logic       flagRegLowW;
   logic       ResetOut;
   logic [1:0] flagIorD;
   logic [1:0] flagALUSrcA;
   logic [2:0] flagALUSrcB;
   logic [2:0] flagALUCtrl;
   logic [2:0] flagRegDist;
   logic [2:0] flagMemReg;
   logic [2:0] flagPCSrc;
   logic [1:0] flagExcpCtrl;

   modport master (
      output OPCode, Funct, Overflow, DivZero, MDDone,
      input  Estado, flagPcWrite, flagIrWrite, flagRegWrite, flagRegA, flagRegB,
             flagALUOut, flagEPC, flagMultStart, flagDivStart, flagRegHighW,
             flagRegLowW, ResetOut, flagIorD, flagALUSrcA, flagALUSrcB,
             flagALUCtrl, flagRegDist, flagMemReg, flagPCSrc, flagExcpCtrl
   );

   modport slave (
      input  OPCode, Funct, Overflow, DivZero, MDDone,
      output Estado, flagPcWrite, flagIrWrite, flagRegWrite, flagRegA, flagRegB,
             flagALUOut, flagEPC, flagMultStart, flagDivStart, flagRegHighW,
             flagRegLowW, ResetOut, flagIorD, flagALUSrcA, flagALUSrcB,
             flagALUCtrl, flagRegDist, flagMemReg, flagPCSrc, flagExcpCtrl
   );
endinterface

// File: rtl/control_seq.sv
// Multicycle control sequencer: fetch with memory-latency wait, decode of a small
// R/I/mult-div instruction set, and a single-cycle exception entry with cause code.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RST      | init $sp from stack constant, assert ResetOut
// FETCH    | issue instruction read, PC <= PC + 4
// FWAIT    | wait MEM_LAT cycles for the read data
// IRLOAD   | capture instruction register
// DECODE   | read A/B, precompute branch target, latch op class
// EXEC_R   | R-type add/sub/and
// EXEC_I   | addi/addiu
// WB_R     | write rd
// WB_I     | write rt
// MD_START | pulse mult/div start (div by zero traps here)
// MD_WAIT  | wait for MDDone, bounded by MD_TIMEOUT
// MD_WB    | write HI/LO
// EXCP     | EPC <= PC - 4, jump to exception vector
module control_seq #(
   parameter int MEM_LAT    = 2,
   parameter int MD_TIMEOUT = 40,
   parameter bit EN_MULTDIV = 1'b1
) (
   input logic         Clock,
   input logic         Reset,
   control_seq_if.slave bus
);

   typedef enum logic [4:0] {
      S_RST      = 5'd0,
      S_FETCH    = 5'd1,
      S_FWAIT    = 5'd2,
      S_IRLOAD   = 5'd3,
      S_DECODE   = 5'd4,
      S_EXEC_R   = 5'd5,
      S_EXEC_I   = 5'd6,
      S_WB_R     = 5'd7,
      S_WB_I     = 5'd8,
      S_MD_START = 5'd9,
      S_MD_WAIT  = 5'd10,
      S_MD_WB    = 5'd11,
      S_EXCP     = 5'd12
   } state_t;

   typedef enum logic [2:0] {
      C_ADD, C_SUB, C_AND, C_MULT, C_DIV, C_ADDI, C_ADDIU, C_NONE
   } op_cls_t;

   state_t     state_q, state_d;
   op_cls_t    cls_q, cls_d, dec_cls;
   logic [3:0] wait_q, wait_d;
   logic [7:0] md_q, md_d;
   logic [1:0] cause_q, cause_d;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= S_RST;
         cls_q   <= C_NONE;
         wait_q  <= '0;
         md_q    <= '0;
         cause_q <= '0;
      end else begin
         state_q <= state_d;
         cls_q   <= cls_d;
         wait_q  <= wait_d;
         md_q    <= md_d;
         cause_q <= cause_d;
      end
   end

   always_comb begin
      dec_cls = C_NONE;
      if (bus.OPCode == 6'b000000) begin
         case (bus.Funct)
            6'b100000: dec_cls = C_ADD;
            6'b100010: dec_cls = C_SUB;
            6'b100100: dec_cls = C_AND;
            6'b011000: dec_cls = EN_MULTDIV ? C_MULT : C_NONE;
            6'b011010: dec_cls = EN_MULTDIV ? C_DIV : C_NONE;
            default:   dec_cls = C_NONE;
         endcase
      end else if (bus.OPCode == 6'b001000) begin
         dec_cls = C_ADDI;
      end else if (bus.OPCode == 6'b001001) begin
         dec_cls = C_ADDIU;
      end
   end

   always_comb begin
      state_d = state_q;
      cls_d   = cls_q;
      wait_d  = wait_q;
      md_d    = md_q;
      cause_d = cause_q;

      bus.Estado        = state_q;
      bus.flagPcWrite   = 1'b0;
      bus.flagIrWrite   = 1'b0;
      bus.flagRegWrite  = 1'b0;
      bus.flagRegA      = 1'b0;
      bus.flagRegB      = 1'b0;
      bus.flagALUOut    = 1'b0;
      bus.flagEPC       = 1'b0;
      bus.flagMultStart = 1'b0;
      bus.flagDivStart  = 1'b0;
      bus.flagRegHighW  = 1'b0;
      bus.flagRegLowW   = 1'b0;
      bus.ResetOut      = 1'b0;
      bus.flagIorD      = 2'b00;
      bus.flagALUSrcA   = 2'b00;
      bus.flagALUSrcB   = 3'b000;
      bus.flagALUCtrl   = 3'b000;
      bus.flagRegDist   = 3'b000;
      bus.flagMemReg    = 3'b000;
      bus.flagPCSrc     = 3'b000;
      bus.flagExcpCtrl  = 2'b00;

      case (state_q)
         S_RST: begin
            bus.flagRegWrite = 1'b1;
            bus.flagRegDist  = 3'b100;
            bus.flagMemReg   = 3'b111;
            bus.ResetOut     = 1'b1;
            state_d          = S_FETCH;
         end
         S_FETCH: begin
            bus.flagALUSrcB = 3'b001;
            bus.flagALUCtrl = 3'b001;
            bus.flagPcWrite = 1'b1;
            wait_d          = 4'(MEM_LAT - 1);
            state_d         = S_FWAIT;
         end
         S_FWAIT: begin
            if (wait_q == 4'd0) state_d = S_IRLOAD;
            else                wait_d  = wait_q - 4'd1;
         end
         S_IRLOAD: begin
            bus.flagIrWrite = 1'b1;
            state_d         = S_DECODE;
         end
         S_DECODE: begin
            bus.flagRegA    = 1'b1;
            bus.flagRegB    = 1'b1;
            bus.flagALUOut  = 1'b1;
            bus.flagALUSrcB = 3'b011;
            bus.flagALUCtrl = 3'b001;
            cls_d           = dec_cls;
            case (dec_cls)
               C_ADD, C_SUB, C_AND: state_d = S_EXEC_R;
               C_MULT, C_DIV:       state_d = S_MD_START;
               C_ADDI, C_ADDIU:     state_d = S_EXEC_I;
               default: begin
                  state_d = S_EXCP;
                  cause_d = 2'b00;
               end
            endcase
         end
         S_EXEC_R: begin
            bus.flagALUSrcA = 2'b01;
            bus.flagALUOut  = 1'b1;
            case (cls_q)
               C_SUB:   bus.flagALUCtrl = 3'b010;
               C_AND:   bus.flagALUCtrl = 3'b011;
               default: bus.flagALUCtrl = 3'b001;
            endcase
            if (bus.Overflow && cls_q != C_AND) begin
               state_d = S_EXCP;
               cause_d = 2'b01;
            end else begin
               state_d = S_WB_R;
            end
         end
         S_EXEC_I: begin
            bus.flagALUSrcA = 2'b01;
            bus.flagALUSrcB = 3'b010;
            bus.flagALUCtrl = 3'b001;
            bus.flagALUOut  = 1'b1;
            if (bus.Overflow && cls_q == C_ADDI) begin
               state_d = S_EXCP;
               cause_d = 2'b01;
            end else begin
               state_d = S_WB_I;
            end
         end
         S_WB_R: begin
            bus.flagRegWrite = 1'b1;
            bus.flagRegDist  = 3'b001;
            state_d          = S_FETCH;
         end
         S_WB_I: begin
            bus.flagRegWrite = 1'b1;
            state_d          = S_FETCH;
         end
         S_MD_START: begin
            md_d = '0;
            // Divide-by-zero is caught before the unit is ever started.
            if (cls_q == C_DIV && bus.DivZero) begin
               state_d = S_EXCP;
               cause_d = 2'b10;
            end else begin
               bus.flagMultStart = (cls_q == C_MULT);
               bus.flagDivStart  = (cls_q == C_DIV);
               state_d           = S_MD_WAIT;
            end
         end
         S_MD_WAIT: begin
            md_d = md_q + 8'd1;
            if (bus.MDDone) begin
               state_d = S_MD_WB;
            end else if (md_q == 8'(MD_TIMEOUT - 1)) begin
               state_d = S_EXCP;
               cause_d = 2'b11;
            end
         end
         S_MD_WB: begin
            bus.flagRegHighW = 1'b1;
            bus.flagRegLowW  = 1'b1;
            state_d          = S_FETCH;
         end
         S_EXCP: begin
            bus.flagEPC      = 1'b1;
            bus.flagALUSrcB  = 3'b001;
            bus.flagALUCtrl  = 3'b010;
            bus.flagExcpCtrl = cause_q;
            bus.flagPCSrc    = 3'b011;
            bus.flagPcWrite  = 1'b1;
            state_d          = S_FETCH;
         end
         default: state_d = S_RST;
      endcase
   end

endmodule
